// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: debounced up/down level selector driving a period-aligned, glitch-free PWM output.
module pwm_level_ctrl #(
    parameter int LEVELS   = 4,
    parameter int PERIOD   = 12,
    parameter int STEP     = 4,
    parameter int DEBOUNCE = 4,
    parameter bit WRAP     = 1'b1
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      i_sw,
    input  logic                      i_sw_dn,
    input  logic                      i_en,
    output logic [$clog2(LEVELS)-1:0] o_pwm_duty,
    output logic                      o_pwm,
    output logic                      o_stop
);
    localparam int LW = $clog2(LEVELS);
    localparam int PW = $clog2(PERIOD + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [LW-1:0] LMAX   = LW'(LEVELS - 1);
    localparam logic [PW-1:0] PMAX   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] STEP_W = PW'(STEP);
    localparam logic [DW-1:0] DMAX   = DW'(DEBOUNCE - 1);

    logic [1:0]         s1, s2, db, db_d, press;
    logic [1:0][DW-1:0] dcnt;
    logic [LW-1:0]      lvl_nx;
    logic [PW-1:0]      cnt, act, duty_cmp;

    // bit 0 = up button, bit 1 = down button
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            dcnt <= '0;
        end else begin
            s1   <= {i_sw_dn, i_sw};
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DMAX) begin
                    db[i]   <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_d;

    always_comb begin
        lvl_nx = o_pwm_duty;
        if (press[0] & ~press[1])
            lvl_nx = (o_pwm_duty == LMAX) ? (WRAP ? '0 : LMAX) : o_pwm_duty + 1'b1;
        else if (press[1] & ~press[0])
            lvl_nx = (o_pwm_duty == '0) ? (WRAP ? LMAX : '0) : o_pwm_duty - 1'b1;
    end

    assign duty_cmp = PW'(o_pwm_duty) * STEP_W;

    // active duty only reloads at a period boundary (or continuously while disabled)
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            o_pwm_duty <= '0;
            cnt        <= '0;
            act        <= '0;
        end else begin
            o_pwm_duty <= lvl_nx;
            if (!i_en || cnt == PMAX) begin
                cnt <= '0;
                act <= duty_cmp;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_pwm  = i_en & (cnt < act);
    assign o_stop = (o_pwm_duty == '0);
endmodule

// File: tb/tb_pwm_level_ctrl.sv
// tb_pwm_level_ctrl: random button stimulus with a scoreboard on level changes, for wrap and saturate variants.
module tb_pwm_level_ctrl;
    localparam int NL = 4;
    localparam int P  = 12;
    localparam int S  = 4;
    localparam int D  = 4;

    typedef struct {
        int lvl;
        int cyc;
    } exp_t;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       i_sw   = 1'b0;
    logic       i_sw_dn = 1'b0;
    logic       i_en   = 1'b0;
    logic [1:0] duty [2];
    logic [1:0] pwm, stop;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lv [2] = '{0, 0};
    int   cur [2] = '{0, 0};
    exp_t qw[$];
    exp_t qs[$];

    pwm_level_ctrl #(.LEVELS(NL), .PERIOD(P), .STEP(S), .DEBOUNCE(D), .WRAP(1'b1)) u_wrap (
        .sysclk(sysclk), .reset(reset), .i_sw(i_sw), .i_sw_dn(i_sw_dn), .i_en(i_en),
        .o_pwm_duty(duty[0]), .o_pwm(pwm[0]), .o_stop(stop[0])
    );

    pwm_level_ctrl #(.LEVELS(NL), .PERIOD(P), .STEP(S), .DEBOUNCE(D), .WRAP(1'b0)) u_sat (
        .sysclk(sysclk), .reset(reset), .i_sw(i_sw), .i_sw_dn(i_sw_dn), .i_en(i_en),
        .o_pwm_duty(duty[1]), .o_pwm(pwm[1]), .o_stop(stop[1])
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d expected %0d", nm, i, cyc, a, e);
        end
    endtask

    // Model: a debounced press at drive cycle t moves the level, landing D+3 cycles later
    task automatic press_model(input bit up, input bit dn, input int t);
        int nw [2];
        if (up == dn) return;
        nw[0] = up ? (lv[0] + 1) % NL : (lv[0] + NL - 1) % NL;
        nw[1] = up ? ((lv[1] < NL - 1) ? lv[1] + 1 : lv[1]) : ((lv[1] > 0) ? lv[1] - 1 : 0);
        for (int i = 0; i < 2; i++) begin
            if (nw[i] != lv[i]) begin
                if (i == 0) qw.push_back('{lvl: nw[i], cyc: t + D + 3});
                else qs.push_back('{lvl: nw[i], cyc: t + D + 3});
                lv[i] = nw[i];
            end
        end
    endtask

    // m: 0 up, 1 down, 2 both, 3 none; l cycles high, then g cycles low
    task automatic seg(input int m, input int l, input int g);
        @(negedge sysclk);
        if (l > 0 && m != 3) begin
            i_sw    = (m == 0 || m == 2);
            i_sw_dn = (m == 1 || m == 2);
            if (l >= D) press_model(m == 0 || m == 2, m == 1 || m == 2, cyc);
            repeat (l) @(negedge sysclk);
            i_sw    = 1'b0;
            i_sw_dn = 1'b0;
        end
        repeat (g) @(negedge sysclk);
    endtask

    // Enable PWM for three periods; bump issues an up press in the first period
    task automatic pwm_run(input bit bump);
        int c0;
        int old [2];
        int lp;
        @(negedge sysclk);
        old  = lv;
        c0   = cyc;
        i_en = 1'b1;
        if (bump) begin
            i_sw = 1'b1;
            press_model(1'b1, 1'b0, c0);
        end
        for (int k = 0; k < 3 * P; k++) begin
            if (k > 0) @(negedge sysclk);
            if (k == P) i_sw = 1'b0;
            #1;
            for (int i = 0; i < 2; i++) begin
                lp = (k >= P) ? lv[i] : old[i];
                chk("pwm_pattern", i, 32'(pwm[i]), 32'((k % P) < lp * S));
            end
        end
        @(negedge sysclk);
        i_en = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("pwm_disabled", i, 32'(pwm[i]), 0);
        repeat (D + 4) @(negedge sysclk);
    endtask

    // Monitor: every change of o_pwm_duty must match the next scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(posedge sysclk);
            #1;
            if (reset) begin
                cur = '{0, 0};
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (int'(duty[i]) != cur[i]) begin
                    if ((i == 0 ? qw.size() : qs.size()) == 0) begin
                        chk("unexpected_level", i, 32'(duty[i]), 32'(cur[i]));
                        cur[i] = int'(duty[i]);
                    end else begin
                        e = (i == 0) ? qw.pop_front() : qs.pop_front();
                        chk("level", i, 32'(duty[i]), 32'(e.lvl));
                        chk("land_cycle", i, 32'(cyc), 32'(e.cyc));
                        cur[i] = e.lvl;
                    end
                end
                chk("stop", i, 32'(stop[i]), 32'(cur[i] == 0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, l, g, r;
        repeat (3) @(negedge sysclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_duty", i, 32'(duty[i]), 0);
            chk("reset_pwm", i, 32'(pwm[i]), 0);
            chk("reset_stop", i, 32'(stop[i]), 1);
        end
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        for (int n = 0; n < 5; n++) seg(0, 3, 2);
        seg(3, 0, D + 4);
        for (int n = 0; n < 5; n++) seg(0, 10, 10);
        pwm_run(1'b0);
        pwm_run(1'b1);
        for (int n = 0; n < 5; n++) seg(1, 10, 10);
        for (int n = 0; n < 2; n++) seg(2, 10, 10);
        for (int n = 0; n < 40; n++) begin
            m = $urandom_range(0, 3);
            l = ($urandom_range(0, 3) != 0) ? $urandom_range(D, D + 5) : $urandom_range(1, D - 1);
            g = $urandom_range(D + 2, D + 6);
            seg(m, l, g);
            if (n % 8 == 7) pwm_run(1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < NL && lv[0] != 2; n++) seg(0, D + 2, D + 3);
        @(negedge sysclk);
        i_en = 1'b1;
        i_sw = 1'b1;
        repeat (3) @(negedge sysclk);
        #1;
        for (int i = 0; i < 2; i++) chk("pwm_pre_reset", i, 32'(pwm[i]), 32'(lv[i] > 0));
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_reset_duty", i, 32'(duty[i]), 0);
            chk("async_reset_pwm", i, 32'(pwm[i]), 0);
            chk("async_reset_stop", i, 32'(stop[i]), 1);
        end
        qw.delete();
        qs.delete();
        lv = '{0, 0};
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        r = cyc;
        press_model(1'b1, 1'b0, r);
        repeat (12) @(negedge sysclk);
        i_sw = 1'b0;
        repeat (20) @(negedge sysclk);
        i_en = 1'b0;
        repeat (2) @(negedge sysclk);
        for (int i = 0; i < 2; i++) begin
            chk("final_level", i, 32'(duty[i]), 32'(lv[i]));
            chk("pending_expectations", i, 32'(i == 0 ? qw.size() : qs.size()), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_level_ctrl.md
# pwm_level_ctrl

Parametrised button-driven PWM speed controller for the wash-motor drive path. Debounces up/down push buttons, steps an N-level duty selector with wrap or saturate mode, and generates a glitch-free PWM output whose duty updates only at period boundaries. It supersedes the fixed 4-level, single-button FSM_PWM and sits between the board switches and the motor driver pin.

## Interface
- LEVELS, 4: number of duty levels (≥2); level range 0..LEVELS-1.
- PERIOD, 12: PWM period in sysclk cycles (≥2).
- STEP, 4: compare increment per level; duty = level*STEP cycles high. Requires (LEVELS-1)*STEP ≤ PERIOD.
- DEBOUNCE, 4: consecutive stable cycles required to accept a button change (≥1).
- WRAP, 1: 1 = wrap at ends; 0 = saturate.
- sysclk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_sw  in  1  level-up button, raw and asynchronous.
- i_sw_dn  in  1  level-down button, raw and asynchronous.
- i_en  in  1  PWM enable.
- o_pwm_duty  out  clog2(LEVELS)  current selected level.
- o_pwm  out  1  PWM output.
- o_stop  out  1  high when o_pwm_duty == 0.

## Operation
- Reset: all synchronizers, debounce counters, and debounced states = 0. o_pwm_duty = 0, PWM counter = 0, active duty = 0, o_pwm = 0, o_stop = 1.
- Per button: 2-flop synchronizer (s1, s2), then debouncer with state db and counter.
  - s2 == db: counter cleared.
  - s2 != db: counter increments; when counter == DEBOUNCE-1 and s2 still differs, db <= s2 and counter clears.
  - Bounce shorter than DEBOUNCE cycles is ignored.
- Press pulse = db & ~db_d (one cycle on db rising edge). Release generates nothing.
- Level update on press pulses:
  - Up only: +1. Down only: −1. Both in the same cycle: no change.
  - At LEVELS-1, up gives 0 if WRAP=1, else holds. At 0, down gives LEVELS-1 if WRAP=1, else holds.
- A button held high through reset deassertion is accepted as one press after the debounce time.
- PWM counter cnt runs 0..PERIOD-1 and wraps while i_en = 1. Active duty loads o_pwm_duty*STEP (width clog2(PERIOD+1)) on the edge where cnt == PERIOD-1, so a new level takes effect at the start of the next period.
- o_pwm = i_en & (cnt < active duty), decoded from registers only.
  - Level 0 gives constant 0.
  - (LEVELS-1)*STEP == PERIOD gives constant 1.
- i_en = 0: cnt held at 0, active duty reloads every cycle, o_pwm = 0. Level changes are still accepted.
- After i_en rises, the first period starts at cnt = 0 with the current level.

## Timing
- Button latency: i_sw first sampled high at edge E0 and held, then o_pwm_duty updates at edge E0+DEBOUNCE+2. Press pulse is high in the cycle before that edge.
- Duty latency: the level change is visible on o_pwm from the first cycle after the next cnt == PERIOD-1 edge. Worst case is PERIOD cycles after the o_pwm_duty change.
- o_stop is combinational from the o_pwm_duty register, with zero added latency.
- Async reset mid-operation clears everything immediately. o_pwm goes low without waiting for a period boundary.

## Test plan
- Reset, then hold i_sw high 10 cycles and low 10 cycles, repeated 5 times (defaults) -> o_pwm_duty 1,2,3,0,1. Each step lands at E0+6; o_stop high only at 0.
- Pulse i_sw high for 3 cycles (shorter than DEBOUNCE), repeated with 2-cycle gaps -> o_pwm_duty stays 0, no press pulses.
- Level 2 with i_en = 1 -> o_pwm high exactly 8 of every 12 cycles. Level 3 -> constant 1. Level 0 -> constant 0.
- Change level from 1 to 2 mid-period (cnt = 5) -> remainder of that period keeps the 4-high pattern; the next period starts with 8 high.
- WRAP=0: 4 down presses from 0 -> stays 0. 5 up presses -> saturates at 3. Up and down debounced on the same edge -> no change.
- Assert reset while a press is mid-debounce and level = 2 -> o_pwm_duty = 0 and o_pwm = 0 at once. With the button still held after reset release, exactly one press gives level 1.
